pci_bus_arbiter: RTL

//   Central PCI bus arbiter sharing the AD/CMD bus among N initiators via active-low REQ/GNT pairs.

---
 rtl/pci_bus_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pci_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pci_bus_arbiter
//  Description : Central PCI bus arbiter. Shares the AD/CMD bus among
//                N_MASTERS initiators through active-low REQ#/GNT# pairs.
//                It provides round-robin fairness and parks the bus on a
//                fixed master when nobody is requesting. A grant is taken
//                back if the bus stays idle too long. Hidden arbitration
//                means a grant can move while a transaction is still on
//                the bus.
//  Ports       : clk, rst         - bus clock, synchronous active-high reset
//                req_n_i          - per-master request, active-low
//                frame_i, irdy_i  - PCI FRAME# / IRDY#, active-low
//                gnt_n_o          - per-master grant, active-low, registered
//                owner_o          - index of the granted (or last granted) master
//                owner_valid_o    - high while any grant is asserted
//                bus_idle_o       - registered FRAME# & IRDY#
//                timeout_evt_o    - one-cycle pulse on a grant timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_bus_arbiter #(
    parameter int N_MASTERS   = 4,
    parameter int PARK_MASTER = 0,
    parameter int GNT_TIMEOUT = 16,
    parameter int OW          = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req_n_i,
    input  logic                 frame_i,
    input  logic                 irdy_i,
    output logic [N_MASTERS-1:0] gnt_n_o,
    output logic [OW-1:0]        owner_o,
    output logic                 owner_valid_o,
    output logic                 bus_idle_o,
    output logic                 timeout_evt_o
);

    localparam int              TW       = $clog2(GNT_TIMEOUT + 1);
    localparam logic [OW-1:0]   PARK_IDX = OW'(PARK_MASTER);
    localparam logic [OW-1:0]   RR_RST   = OW'(N_MASTERS - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(GNT_TIMEOUT - 1);
    localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PARK  = 2'd1,
        S_GRANT = 2'd2,
        S_OWNED = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [OW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [N_MASTERS-1:0]   gnt_n_q, gnt_n_d;
    logic                   owner_valid_q;
    logic                   bus_idle_q;
    logic                   timeout_evt_q, timeout_evt_d;

    logic                   w_start;
    logic                   w_any_req;
    logic                   w_other_req;
    logic                   w_park_others;
    logic                   w_park_req;
    logic [OW-1:0]          w_winner;
    logic                   w_found;
    int                     w_sum;
    logic [OW-1:0]          w_idx;

    // A transaction starts when FRAME# falls after a cycle of idle bus. Using
    // the registered idle flag makes a hidden-granted master wait for the
    // previous owner's transaction to finish before its start is recognised.
    assign w_start       = bus_idle_q & ~frame_i;
    assign w_any_req     = ~&req_n_i;
    assign w_other_req   = |(~req_n_i & ~(ONE << owner_q));
    assign w_park_others = |(~req_n_i & ~(ONE << PARK_IDX));
    assign w_park_req    = ~req_n_i[PARK_IDX];

    // Round-robin search: first requester after rr_ptr, wrapping modulo N.
    always_comb begin
        w_winner = rr_ptr_q;
        w_found  = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int i = 1; i <= N_MASTERS; i++) begin
            w_sum = int'(rr_ptr_q) + i;
            if (w_sum >= N_MASTERS) begin
                w_sum = w_sum - N_MASTERS;
            end
            w_idx = OW'(w_sum);
            if (!w_found && !req_n_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        tmo_d         = '0;
        timeout_evt_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    state_d  = S_GRANT;
                    owner_d  = w_winner;
                    rr_ptr_d = w_winner;
                end else begin
                    state_d  = S_PARK;
                    owner_d  = PARK_IDX;
                end
            end
            S_PARK: begin
                // Another master must go through IDLE so grants never
                // switch directly from one master to another.
                if (w_start) begin
                    state_d = S_OWNED;
                end else if (w_park_others) begin
                    state_d = S_IDLE;
                end else if (w_park_req) begin
                    state_d  = S_GRANT;
                    rr_ptr_d = PARK_IDX;
                end
            end
            S_GRANT: begin
                if (w_start) begin
                    state_d = S_OWNED;
                end else if (req_n_i[owner_q]) begin
                    state_d = S_IDLE;
                end else if (bus_idle_q && (tmo_q == TMO_LAST)) begin
                    state_d       = S_IDLE;
                    timeout_evt_d = 1'b1;
                end else if (bus_idle_q) begin
                    tmo_d = tmo_q + TW'(1);
                end else begin
                    // Previous owner still on the bus: hold the count.
                    tmo_d = tmo_q;
                end
            end
            S_OWNED: begin
                // A competing request withdraws GNT at once; the current
                // owner still completes its transaction on the bus.
                if (w_other_req || bus_idle_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grants are a registered decode of the next state.
    always_comb begin
        gnt_n_d = '1;
        if (state_d != S_IDLE) begin
            gnt_n_d[owner_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            owner_q       <= PARK_IDX;
            rr_ptr_q      <= RR_RST;
            tmo_q         <= '0;
            gnt_n_q       <= '1;
            owner_valid_q <= 1'b0;
            bus_idle_q    <= 1'b1;
            timeout_evt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            tmo_q         <= tmo_d;
            gnt_n_q       <= gnt_n_d;
            owner_valid_q <= (state_d != S_IDLE);
            bus_idle_q    <= frame_i & irdy_i;
            timeout_evt_q <= timeout_evt_d;
        end
    end

    assign gnt_n_o       = gnt_n_q;
    assign owner_o       = owner_q;
    assign owner_valid_o = owner_valid_q;
    assign bus_idle_o    = bus_idle_q;
    assign timeout_evt_o = timeout_evt_q;

endmodule
`default_nettype wire
